// File: rtl/rc4_pkg.sv
// rc4_pkg: shared definitions for the RC4 decrypt stage.
//   decrypt_state_t  - PRGA/decrypt FSM states
//   MSG_LEN_DEFAULT  - default message length in bytes
//   CHAR_*           - bounds of the accepted plaintext alphabet
package rc4_pkg;

  localparam int MSG_LEN_DEFAULT = 32;

  localparam logic [7:0] CHAR_A     = 8'h61;
  localparam logic [7:0] CHAR_Z     = 8'h7A;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INC_I,
    ST_RD_SI,
    ST_GET_SI,
    ST_RD_SJ,
    ST_GET_SJ,
    ST_WR_I,
    ST_WR_J,
    ST_RD_F,
    ST_GET_F,
    ST_WR_DEC,
    ST_DONE
  } decrypt_state_t;

endpackage

// File: rtl/rc4_char_check.sv
// rc4_char_check: combinational plaintext validity test.
//   i_char  - decrypted byte
//   o_valid - 1 when the byte is lowercase ASCII (a..z) or space
module rc4_char_check
  import rc4_pkg::*;
(
  input  logic [7:0] i_char,
  output logic       o_valid
);

  assign o_valid = ((i_char >= CHAR_A) && (i_char <= CHAR_Z)) || (i_char == CHAR_SPACE);

endmodule

// File: rtl/rc4_decrypt.sv
// rc4_decrypt: RC4 keystream generation (PRGA) and message decryption.
// Walks the scrambled S array, XORs each keystream byte with the
// encrypted ROM and writes plaintext to the decrypted RAM, aborting on
// the first byte outside {a..z, space}. Ten cycles per byte.
//   clk, reset (sync, active-low)
//   start (in)  level, sampled in IDLE     done/busy/fail (out) status
//   s_address/s_data/s_wren/s_q           shared S RAM port
//   enc_address/enc_q                     encrypted message ROM
//   dec_address/dec_data/dec_wren         decrypted message RAM
module rc4_decrypt
  import rc4_pkg::*;
#(
  parameter  int MSG_LEN = MSG_LEN_DEFAULT,
  localparam int AW      = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          done,
  output logic          busy,
  output logic          fail,
  output logic [7:0]    s_address,
  output logic [7:0]    s_data,
  output logic          s_wren,
  input  logic [7:0]    s_q,
  output logic [AW-1:0] enc_address,
  input  logic [7:0]    enc_q,
  output logic [AW-1:0] dec_address,
  output logic [7:0]    dec_data,
  output logic          dec_wren
);

  localparam logic [AW-1:0] K_LAST = AW'(MSG_LEN - 1);

  decrypt_state_t r_state, w_next;

  logic [7:0]    r_i, r_j, r_si, r_sj, r_f, r_enc;
  logic [AW-1:0] r_k;
  logic          r_fail;
  logic [7:0]    w_dec_byte;
  logic          w_valid;

  // Decrypted byte comes from registered f and ciphertext only, so no
  // RAM output ever reaches an output port combinationally.
  assign w_dec_byte = r_f ^ r_enc;

  rc4_char_check u_char_check (
    .i_char  (w_dec_byte),
    .o_valid (w_valid)
  );

  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    done        = 1'b0;
    s_address   = 8'h00;
    s_data      = 8'h00;
    s_wren      = 1'b0;
    enc_address = '0;
    dec_address = '0;
    dec_data    = 8'h00;
    dec_wren    = 1'b0;
    case (r_state)
      ST_IDLE:   if (start) w_next = ST_INC_I;
      ST_INC_I:  begin enc_address = r_k; w_next = ST_RD_SI; end
      ST_RD_SI:  begin enc_address = r_k; s_address = r_i; w_next = ST_GET_SI; end
      ST_GET_SI: begin enc_address = r_k; w_next = ST_RD_SJ; end
      ST_RD_SJ:  begin enc_address = r_k; s_address = r_j; w_next = ST_GET_SJ; end
      ST_GET_SJ: begin enc_address = r_k; w_next = ST_WR_I; end
      ST_WR_I: begin
        enc_address = r_k;
        s_address   = r_i;
        s_data      = r_sj;
        s_wren      = 1'b1;
        w_next      = ST_WR_J;
      end
      ST_WR_J: begin
        enc_address = r_k;
        s_address   = r_j;
        s_data      = r_si;
        s_wren      = 1'b1;
        w_next      = ST_RD_F;
      end
      // After the swap S[i]+S[j] equals si+sj, so the old values index f.
      ST_RD_F:   begin enc_address = r_k; s_address = r_si + r_sj; w_next = ST_GET_F; end
      ST_GET_F:  begin enc_address = r_k; w_next = ST_WR_DEC; end
      ST_WR_DEC: begin
        dec_address = r_k;
        dec_data    = w_dec_byte;
        dec_wren    = 1'b1;
        if (!w_valid || (r_k == K_LAST)) w_next = ST_DONE;
        else                             w_next = ST_INC_I;
      end
      ST_DONE: begin done = 1'b1; w_next = ST_IDLE; end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_i    <= 8'h00;
      r_j    <= 8'h00;
      r_si   <= 8'h00;
      r_sj   <= 8'h00;
      r_f    <= 8'h00;
      r_enc  <= 8'h00;
      r_k    <= '0;
      r_fail <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (start) begin
          r_i    <= 8'h00;
          r_j    <= 8'h00;
          r_k    <= '0;
          r_fail <= 1'b0;
        end
        ST_INC_I:  r_i <= r_i + 8'd1;
        ST_GET_SI: begin r_si <= s_q; r_j <= r_j + s_q; end
        ST_GET_SJ: r_sj <= s_q;
        ST_GET_F:  begin r_f <= s_q; r_enc <= enc_q; end
        ST_WR_DEC: begin
          if (!w_valid)            r_fail <= 1'b1;
          else if (r_k != K_LAST)  r_k    <= r_k + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != ST_IDLE);
  assign fail = r_fail;

endmodule

// File: doc/rc4_decrypt.md
# rc4_decrypt

RC4 keystream-generation and decryption stage (PRGA), directly downstream of the init/scramble controller. After the controller reports scrambling done, it starts this block. The block walks the scrambled S array in the shared S RAM, XORs each keystream byte with the encrypted-message ROM, and writes plaintext to the decrypted RAM. It aborts early, flagging `fail`, on the first byte that is not lowercase ASCII or space.

## Interface
- `MSG_LEN`, 32: message length in bytes (1–256).
- `clk`  in  1  sole clock; all logic rising-edge.
- `reset`  in  1  synchronous, active-low; 0 on a rising edge resets the block.
- `start`  in  1  level; sampled only in IDLE.
- `done`  out  1  one-cycle pulse at completion or abort.
- `busy`  out  1  high in every state except IDLE.
- `fail`  out  1  sticky abort flag; cleared on accepted `start`.
- `s_address`  out  8  S RAM address.
- `s_data`  out  8  S RAM write data.
- `s_wren`  out  1  S RAM write enable.
- `s_q`  in  8  S RAM read data.
- `enc_address`  out  $clog2(MSG_LEN)  encrypted ROM address.
- `enc_q`  in  8  encrypted ROM data.
- `dec_address`  out  $clog2(MSG_LEN)  decrypted RAM address.
- `dec_data`  out  8  decrypted RAM write data.
- `dec_wren`  out  1  decrypted RAM write enable.

## Operation
- Registers: `i`, `j`, `si`, `sj`, `f` (8 b each); byte counter `k`. All 8-bit arithmetic wraps mod 256.
- The RAM/ROM registers the address on the clock edge. `q` is valid in the cycle after the address is first driven.
- States and transitions (one cycle each unless noted):
  - IDLE: on `start`=1, set i←0, j←0, k←0, fail←0; go to INC_I. Otherwise stay.
  - INC_I: i←i+1; `enc_address`=k from here through GET_F.
  - RD_SI: `s_address`=i.
  - GET_SI: si←s_q; j←j+s_q.
  - RD_SJ: `s_address`=j.
  - GET_SJ: sj←s_q.
  - WR_I: `s_address`=i, `s_data`=sj, `s_wren`=1.
  - WR_J: `s_address`=j, `s_data`=si, `s_wren`=1.
  - RD_F: `s_address`=si+sj.
  - GET_F: f←s_q; latch enc_q.
  - WR_DEC: `dec_address`=k, `dec_data`=f^enc, `dec_wren`=1.
    - Byte invalid (not 0x61–0x7A and not 0x20): fail←1, go to DONE.
    - Else if k==MSG_LEN-1: go to DONE.
    - Else: k←k+1, go to INC_I.
  - DONE: `done`=1; go to IDLE.
- i==j: both writes target the same cell with the same value; no special case.
- An invalid byte is still written to the decrypted RAM before the abort.
- `start` while busy: ignored. `start` still high on return to IDLE: a new run begins. S is not re-initialised; that is the controller's job.
- `reset`=0 in any state: next state IDLE, all registers 0, all outputs 0. Any partial writes already made to RAM remain.

## Timing
- Reset values: every output 0; `fail` 0.
- 10 cycles per byte. With `start` accepted at edge E0, `done` is high in cycle 10·MSG_LEN+1 after E0 (321 for MSG_LEN=32).
- Abort on byte k: `done` high in cycle 10·(k+1)+1 after E0.
- `s_wren` is high in exactly 2 cycles per byte. `dec_wren` is high in exactly 1 cycle per byte. Write enables are never high in IDLE or DONE.
- `busy` rises in the cycle after `start` is accepted. `busy` falls in the cycle after `done`.
- `fail` is valid from the `done` cycle and holds until the next accepted `start` or reset.
- Address and write outputs are decoded from the state register plus data registers only, never directly from `s_q`/`enc_q`.

## Structure
- Shared package `rc4_pkg`:
  - state enum `decrypt_state_t`,
  - `MSG_LEN_DEFAULT`=32,
  - constants `CHAR_A`=8'h61, `CHAR_Z`=8'h7A, `CHAR_SPACE`=8'h20.
- One combinational sub-module, `rc4_char_check`: 8-bit in, `valid` out.

## Test plan
- Identity S (S[x]=x), enc[0]=0x63: i=j=1, f=S[2]=0x02; WR_DEC for k=0 writes dec[0]=0x61 in cycle 10 after start; exactly 2 `s_wren` pulses precede it.
- Golden-model S and ciphertext with an all-valid 32-byte plaintext: all 32 dec bytes match the model; `done` in cycle 321; `fail`=0; final S equals the model.
- Identity S, enc[0]=0x00: dec[0]=0x02 written; `fail`=1; `done` in cycle 11; `dec_wren` never pulses again.
- `start` toggled during cycles 5–200 of a run: no restart; `done` still at cycle 321; `start` after `done` restarts with i=j=k=0.
- `reset`=0 asserted at cycle 57 mid-run: next cycle all outputs 0, `busy`=0; `start` afterward runs a full, correct sequence.
- MSG_LEN=1: single byte processed; `done` in cycle 11; `enc_address`/`dec_address` stay 0.
